// File: rtl/bin_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : bin_frame_packer
// Purpose  : Packs a binarized pixel stream into WORD_W-bit framebuffer
//            words. The camera valid/coordinate stream is delayed DELAY
//            cycles so it lines up with bin_in. Accepted pixels are packed
//            LSB-first (bit k = column word_base + k) and written with a
//            linear word address. A frame starts at an accepted (0,0) and
//            ends when its last word is written.
// Ports    : clk_in, rst_in (async, active-high)
//            valid_in, hcount_in, vcount_in : undelayed camera strobe/coords
//            bin_in                         : pixel bit, DELAY cycles later
//            we_out, addr_out, data_out     : registered BRAM write port
//            frame_done_out                 : 1-cycle pulse after last word
//            ones_count_out                 : only with BIN_PACK_ONES_COUNT_EN
// Macro    : BIN_PACK_ONES_COUNT_EN adds the per-frame count of 1 pixels.
// Revision : 1.0 - initial release
// ============================================================================
module bin_frame_packer #(
    parameter int H_PIX  = 320,
    parameter int V_PIX  = 240,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 13,
    parameter int DELAY  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              valid_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              bin_in,
    output logic              we_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [WORD_W-1:0] data_out,
`ifdef BIN_PACK_ONES_COUNT_EN
    output logic [ADDR_W+4:0] ones_count_out,
`endif
    output logic              frame_done_out
);

    localparam int                c_WPR      = H_PIX / WORD_W;
    localparam int                c_BIT_W    = $clog2(WORD_W);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(H_PIX * V_PIX / WORD_W - 1);
    localparam logic [c_BIT_W-1:0] c_TOP_BIT = c_BIT_W'(WORD_W - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        CAPTURE  = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    // Alignment delay line for the strobe and coordinates.
    logic [DELAY-1:0]       r_vld_dly;
    logic [DELAY-1:0][10:0] r_h_dly;
    logic [DELAY-1:0][9:0]  r_v_dly;

    logic              r_pend;
    logic [ADDR_W-1:0] r_idx;
    logic [WORD_W-1:0] r_acc;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;
    logic              r_done_pend;
    logic              r_frame_done;

    logic               w_vld;
    logic [10:0]        w_h;
    logic [9:0]         w_v;
    logic               w_accept;
    logic               w_sof;
    logic [ADDR_W-1:0]  w_idx;
    logic [c_BIT_W-1:0] w_bit;
    logic               w_take;
    logic               w_flush;
    logic               w_full;
    logic               w_we_nxt;
    logic               w_pend_nxt;
    logic               w_done;
    logic [WORD_W-1:0]  w_acc_nxt;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [WORD_W-1:0]  w_wr_data;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vld_dly <= '0;
            r_h_dly   <= '0;
            r_v_dly   <= '0;
        end else begin
            r_vld_dly[0] <= valid_in;
            r_h_dly[0]   <= hcount_in;
            r_v_dly[0]   <= vcount_in;
            for (int i = 1; i < DELAY; i++) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
                r_h_dly[i]   <= r_h_dly[i-1];
                r_v_dly[i]   <= r_v_dly[i-1];
            end
        end
    end

    assign w_vld    = r_vld_dly[DELAY-1];
    assign w_h      = r_h_dly[DELAY-1];
    assign w_v      = r_v_dly[DELAY-1];
    assign w_accept = w_vld && (32'(w_h) < H_PIX) && (32'(w_v) < V_PIX);
    assign w_sof    = w_accept && (w_h == 11'd0) && (w_v == 10'd0);
    assign w_idx    = ADDR_W'(32'(w_v) * c_WPR + 32'(w_h) / WORD_W);
    assign w_bit    = c_BIT_W'(32'(w_h) % WORD_W);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and write decision
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_flush     = 1'b0;
        w_full      = 1'b0;
        w_acc_nxt   = r_acc;
        w_pend_nxt  = r_pend;
        w_done      = 1'b0;

        case (r_state)
            WAIT_SOF: begin
                if (w_sof) begin
                    w_take      = 1'b1;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_accept) begin
                    w_take  = 1'b1;
                    w_flush = r_pend && (w_idx != r_idx);
                end
            end
            default: w_state_nxt = WAIT_SOF;
        endcase

        if (w_take) begin
            // A flushed or already-written word restarts from all zeros;
            // otherwise the bit is merged (a duplicate overwrites its bit).
            w_acc_nxt        = (w_flush || !r_pend) ? '0 : r_acc;
            w_acc_nxt[w_bit] = bin_in;
            w_full           = (w_bit == c_TOP_BIT);
            // If a flush and a completion coincide (column jump landing on
            // the top bit), the flush wins this cycle and the new word stays
            // pending until the next index change.
            w_pend_nxt       = !(w_full && !w_flush);
        end

        w_we_nxt  = w_flush || w_full;
        w_wr_addr = w_flush ? r_idx : w_idx;
        w_wr_data = w_flush ? r_acc : w_acc_nxt;

        // A flush forced by a new (0,0) aborts the frame without completion.
        if (w_we_nxt && (w_wr_addr == c_LAST_IDX) && !w_sof) begin
            w_done      = 1'b1;
            w_pend_nxt  = 1'b0;
            w_state_nxt = WAIT_SOF;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pend       <= 1'b0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_done_pend  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_we   <= w_we_nxt;
            r_pend <= w_pend_nxt;
            if (w_we_nxt) begin
                r_addr <= w_wr_addr;
                r_data <= w_wr_data;
            end
            if (w_take) begin
                r_acc <= w_acc_nxt;
                r_idx <= w_idx;
            end
            // Delayed one extra cycle so the pulse follows the last we_out.
            r_done_pend  <= w_done;
            r_frame_done <= r_done_pend;
        end
    end

    assign we_out         = r_we;
    assign addr_out       = r_addr;
    assign data_out       = r_data;
    assign frame_done_out = r_frame_done;

`ifdef BIN_PACK_ONES_COUNT_EN
    logic [ADDR_W+4:0] r_ones;
    logic [ADDR_W+4:0] r_ones_out;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ones     <= '0;
            r_ones_out <= '0;
        end else begin
            if (w_sof) begin
                r_ones <= (ADDR_W+5)'(bin_in);
            end else if (w_take && bin_in) begin
                r_ones <= r_ones + 1'b1;
            end
            // Latched together with frame_done_out, after the last pixel
            // of the frame has been counted.
            if (r_done_pend) begin
                r_ones_out <= r_ones;
            end
        end
    end

    assign ones_count_out = r_ones_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_frame_packer
// Purpose  : Self-checking bench for bin_frame_packer on a reduced frame
//            geometry. Expected writes are derived from a pixel image array;
//            bin_in is replayed DELAY cycles after its strobe from a ring.
// Macro    : BIN_PACK_ONES_COUNT_EN enables the ones_count_out checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_frame_packer;

    localparam int H_PIX  = 64;
    localparam int V_PIX  = 12;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 6;
    localparam int DELAY  = 4;
    localparam int NW     = H_PIX * V_PIX / WORD_W;
    localparam int WPR    = H_PIX / WORD_W;

    logic              clk_in    = 1'b0;
    logic              rst_in    = 1'b1;
    logic              valid_in  = 1'b0;
    logic [10:0]       hcount_in = '0;
    logic [9:0]        vcount_in = '0;
    logic              bin_in    = 1'b0;
    logic              we_out;
    logic [ADDR_W-1:0] addr_out;
    logic [WORD_W-1:0] data_out;
    logic              frame_done_out;
`ifdef BIN_PACK_ONES_COUNT_EN
    logic [ADDR_W+4:0] ones_count_out;
`endif

    bin_frame_packer #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX),
        .WORD_W(WORD_W),
        .ADDR_W(ADDR_W),
        .DELAY (DELAY)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .bin_in        (bin_in),
        .we_out        (we_out),
        .addr_out      (addr_out),
        .data_out      (data_out),
`ifdef BIN_PACK_ONES_COUNT_EN
        .ones_count_out(ones_count_out),
`endif
        .frame_done_out(frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // bin value for cycle c lives in slot c%16; written DELAY cycles ahead.
    logic bin_ring [16];
    always @(posedge clk_in) begin
        #1;
        bin_in = bin_ring[cyc % 16];
    end

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;
    wr_t wq[$];
    int  done_q[$];

    always @(negedge clk_in) begin
        if (we_out === 1'b1) wq.push_back('{int'(addr_out), int'(data_out), cyc});
        if (frame_done_out === 1'b1) done_q.push_back(cyc);
    end

    logic img [V_PIX][H_PIX];
    int   exp_ones;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input int h, input int vv, input logic b);
        valid_in  = v;
        hcount_in = 11'(h);
        vcount_in = 10'(vv);
        bin_ring[(cyc + DELAY) % 16] = b;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom % 2048, $urandom % 1024, 1'($urandom % 2));
    endtask

    function automatic logic [WORD_W-1:0] exp_word(input int i);
        logic [WORD_W-1:0] w;
        int r, c;
        r = i / WPR;
        c = (i % WPR) * WORD_W;
        for (int k = 0; k < WORD_W; k++) w[k] = img[r][c + k];
        return w;
    endfunction

    // mode 0: even columns set, 1: checkerboard, 2: random with gaps,
    // duplicates and out-of-range strobes.
    task automatic send_frame(input int mode);
        logic b;
        exp_ones = 0;
        for (int v = 0; v < V_PIX; v++) begin
            for (int h = 0; h < H_PIX; h++) begin
                case (mode)
                    0:       b = (h % 2 == 0);
                    1:       b = ((h + v) % 2 == 0);
                    default: b = 1'($urandom % 2);
                endcase
                if (mode == 2 && $urandom % 8 == 0) idle(1 + $urandom % 3);
                img[v][h] = b;
                step(1'b1, h, v, b);
                exp_ones += int'(b);
                if (mode == 2 && (h % WORD_W) != WORD_W - 1 && (h != 0 || v != 0)
                    && $urandom % 16 == 0) begin
                    b = 1'($urandom % 2);
                    img[v][h] = b;
                    step(1'b1, h, v, b);
                    exp_ones += int'(b);
                end
            end
            for (int k = 0; k < 3; k++) step(1'b1, H_PIX + k, v, 1'b1);
        end
        idle(8);
    endtask

    task automatic check_frame(input string tag);
        int n;
        chk({tag, " write count"}, 64'(wq.size()), 64'(NW));
        n = (wq.size() < NW) ? wq.size() : NW;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 64'(wq[i].a), 64'(i));
            chk($sformatf("%s data[%0d]", tag, i), 64'(wq[i].d), 64'(exp_word(i)));
        end
        chk({tag, " frame_done count"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0 && wq.size() > 0)
            chk({tag, " frame_done timing"}, 64'(done_q[0]), 64'(wq[wq.size()-1].c + 1));
`ifdef BIN_PACK_ONES_COUNT_EN
        chk({tag, " ones_count"}, 64'(ones_count_out), 64'(exp_ones));
`endif
    endtask

    initial begin
        logic [WORD_W-1:0] lat_bits;
        logic [WORD_W-1:0] w1_bits;
        int t15;

        foreach (bin_ring[i]) bin_ring[i] = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset we_out", 64'(we_out), 64'd0);
        chk("reset addr_out", 64'(addr_out), 64'd0);
        chk("reset data_out", 64'(data_out), 64'd0);
        chk("reset frame_done", 64'(frame_done_out), 64'd0);
`ifdef BIN_PACK_ONES_COUNT_EN
        chk("reset ones_count", 64'(ones_count_out), 64'd0);
`endif
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        idle(3);

        // First word: h=15 strobe at cycle t must write at t+DELAY+1.
        wq.delete();
        lat_bits = WORD_W'($urandom);
        t15 = 0;
        for (int h = 0; h < WORD_W; h++) begin
            if (h == WORD_W - 1) t15 = cyc;
            step(1'b1, h, 0, lat_bits[h]);
        end
        idle(8);
        chk("latency write count", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) begin
            chk("latency cycle", 64'(wq[0].c), 64'(t15 + DELAY + 1));
            chk("latency addr", 64'(wq[0].a), 64'd0);
            chk("latency data", 64'(wq[0].d), 64'(lat_bits));
        end

        // Second word, then a partial third word killed by async reset.
        w1_bits = WORD_W'($urandom) | 16'h0001;
        for (int h = 0; h < WORD_W; h++) step(1'b1, WORD_W + h, 0, w1_bits[h]);
        for (int h = 0; h < 10; h++) step(1'b1, 2 * WORD_W + h, 0, 1'b1);
        idle(6);
        chk("hold addr", 64'(addr_out), 64'd1);
        chk("hold data", 64'(data_out), 64'(w1_bits));
        wq.delete();
        #2;
        rst_in = 1'b1;
        #1;
        chk("async rst we_out", 64'(we_out), 64'd0);
        chk("async rst addr_out", 64'(addr_out), 64'd0);
        chk("async rst data_out", 64'(data_out), 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        idle(10);
        chk("no partial write after rst", 64'(wq.size()), 64'd0);

        // Stream joined mid-frame: nothing until the next (0,0).
        wq.delete();
        done_q.delete();
        for (int v = 5; v < V_PIX; v++)
            for (int h = (v == 5) ? 40 : 0; h < H_PIX; h++) step(1'b1, h, v, 1'($urandom % 2));
        idle(8);
        chk("midstream writes", 64'(wq.size()), 64'd0);
        chk("midstream frame_done", 64'(done_q.size()), 64'd0);

        // Full frame, even columns set.
        wq.delete();
        done_q.delete();
        send_frame(0);
        check_frame("even");
        if (wq.size() > 0) chk("even data 5555", 64'(wq[0].d), 64'h5555);
`ifdef BIN_PACK_ONES_COUNT_EN
        idle(20);
        chk("ones_count held", 64'(ones_count_out), 64'(H_PIX * V_PIX / 2));
`endif

        // Column jump inside row 2 flushes a partial word.
        wq.delete();
        done_q.delete();
        step(1'b1, 0, 0, 1'b1);
        for (int h = 0; h < 8; h++) step(1'b1, h, 2, 1'b1);
        step(1'b1, 2 * WORD_W, 2, 1'b0);
        idle(8);
        chk("jump write count", 64'(wq.size()), 64'd2);
        if (wq.size() > 1) begin
            chk("jump first addr", 64'(wq[0].a), 64'd0);
            chk("jump first data", 64'(wq[0].d), 64'h0001);
            chk("jump flush addr", 64'(wq[1].a), 64'(2 * WPR));
            chk("jump flush data", 64'(wq[1].d), 64'h00FF);
        end
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        idle(4);

        // Random frame with gaps, duplicates and out-of-range strobes.
        wq.delete();
        done_q.delete();
        send_frame(2);
        check_frame("random");

        // Checkerboard frame.
        wq.delete();
        done_q.delete();
        send_frame(1);
        check_frame("checker");
`ifdef BIN_PACK_ONES_COUNT_EN
        chk("checker ones half", 64'(ones_count_out), 64'(H_PIX * V_PIX / 2));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_frame_packer.md
Name: bin_frame_packer

Overview:
- Sits directly downstream of the pixel binarizer and upstream of the 1-bit QR framebuffer BRAM.
- Delays the camera valid/coordinate stream internally so it lines up with the binarized pixel.
- Packs WORD_W consecutive pixels of a row into one word and issues BRAM writes with a linear word address.
- Frames are delimited by coordinates; a one-cycle pulse marks each completed frame for the decoder.

Parameters:
- H_PIX, 320, active pixels per row; must be a multiple of WORD_W.
- V_PIX, 240, active rows per frame.
- WORD_W, 16, pixels per BRAM word; must be at least 2.
- ADDR_W, 13, word address width; must satisfy 2^ADDR_W >= H_PIX*V_PIX/WORD_W.
- DELAY, 4, cycles from valid_in/coordinates to the matching bin_in.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-high reset.
- valid_in, input, 1, camera pixel strobe, undelayed.
- hcount_in, input, 11, pixel column, undelayed.
- vcount_in, input, 10, pixel row, undelayed.
- bin_in, input, 1, binarized pixel, valid DELAY cycles after its valid_in.
- we_out, output, 1, BRAM write enable.
- addr_out, output, ADDR_W, BRAM word address.
- data_out, output, WORD_W, packed pixels; bit k is column (word_base + k).
- frame_done_out, output, 1, one-cycle pulse after the last word of a frame is written.

Behaviour:
- Reset: asynchronous, active-high. Clears the delay line, the accumulator, pending flag and state. we_out=0, addr_out=0, data_out=0, frame_done_out=0, state=WAIT_SOF.
- Reset asserted mid-frame discards the partial word with no write; capture restarts at the next (0,0).
- Alignment: valid_in, hcount_in and vcount_in pass through a DELAY-stage shift register; the delayed copies are paired with bin_in.
- Acceptance: a pixel is accepted when delayed valid=1, h<H_PIX and v<V_PIX; all other pixels are ignored.
- Index rules: word_idx = v*(H_PIX/WORD_W) + h/WORD_W, computed in ADDR_W bits; bit = h mod WORD_W.
- State WAIT_SOF:
  - Ignores everything until an accepted pixel at (0,0).
  - That pixel loads bit 0, sets pending, and moves to CAPTURE.
- State CAPTURE, per accepted pixel:
  - If pending and word_idx differs from the held index, the partial word is flushed: unwritten bits are 0, and it is written the same cycle.
  - The pixel bit is then stored in a fresh accumulator.
  - When bit==WORD_W-1, the full word is written on the next cycle and pending clears.
- An accepted (0,0) in CAPTURE flushes any pending word and begins a new frame; no frame_done is issued for the aborted frame.
- At most one write per cycle, guaranteed by WORD_W>=2.
- Write timing: we_out, addr_out and data_out are registered. we_out pulses 1 cycle after the accepted pixel that completes or flushes the word, i.e. DELAY+1 cycles after that pixel's valid_in. addr_out/data_out hold their value when we_out=0.
- Frame end: writing the word at index H_PIX*V_PIX/WORD_W-1 asserts frame_done_out on the cycle after that we_out, then state returns to WAIT_SOF.
- Duplicate coordinates: an accepted pixel repeating the current h,v overwrites its bit.

Optional Feature:
- Macro BIN_PACK_ONES_COUNT_EN.
- Defined: adds output ones_count_out, width ADDR_W+5. It counts accepted pixels equal to 1 since the frame's (0,0), latched on the frame_done_out cycle and held until the next frame_done_out. Reset value is 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- DELAY=4 full frame with bin_in=1 at even columns only -> 4800 writes at addr 0..4799, each data_out=16'h5555; a single frame_done_out 1 cycle after the addr 4799 write.
- Pixel (h=15,v=0) valid at cycle t -> we_out=1 at t+5, addr_out=0.
- Frame starting mid-stream at (100,50), then a full frame -> no writes until (0,0); then exactly 4800 writes.
- Pixels h=0..7 of row 2 all 1, then a jump to h=32 -> flush at addr 40 with data 16'h00FF; no write for addr 41.
- rst_in pulsed async mid-word at h=9 -> outputs 0 immediately; no write for the partial word; the next frame captures normally.
- BIN_PACK_ONES_COUNT_EN with a checkerboard frame -> ones_count_out=38400 on frame_done_out and held; with the macro undefined the bench compiles without the port.
